// File: rtl/cr_prefix_fe_seq_if.sv
// cr_prefix_fe_seq_if
// Bundles every non-clock signal of the prefix feature-extraction sequencer:
//   input word side  : in_valid, in_ready, in_data, in_bytes, in_eop
//   comparator side  : fe_char_out, fe_char_valid, fe_match_in
//   result side      : res_valid, res_ready, res_vec, res_char_cnt, res_trunc
// slave  = the sequencer itself
// master = the surroundings (input FIFO, comparator bank, table lookup)
interface cr_prefix_fe_seq_if #(
  parameter int NUM_FE = 16,
  parameter int CNT_W  = 9
) ();
  logic              in_valid;
  logic              in_ready;
  logic [63:0]       in_data;
  logic [3:0]        in_bytes;
  logic              in_eop;
  logic [7:0]        fe_char_out;
  logic              fe_char_valid;
  logic [NUM_FE-1:0] fe_match_in;
  logic              res_valid;
  logic              res_ready;
  logic [NUM_FE-1:0] res_vec;
  logic [CNT_W-1:0]  res_char_cnt;
  logic              res_trunc;

  modport slave (
    input  in_valid, in_data, in_bytes, in_eop, fe_match_in, res_ready,
    output in_ready, fe_char_out, fe_char_valid, res_valid, res_vec,
           res_char_cnt, res_trunc
  );

  modport master (
    output in_valid, in_data, in_bytes, in_eop, fe_match_in, res_ready,
    input  in_ready, fe_char_out, fe_char_valid, res_valid, res_vec,
           res_char_cnt, res_trunc
  );
endinterface

// File: rtl/cr_prefix_fe_seq.sv
// cr_prefix_fe_seq
// Serializes 64-bit packet words onto the shared comparator char bus, one byte
// per cycle, ORs the comparators' registered match vectors into a per-packet
// feature vector and hands it out with the compared character count.
// Ports:
//   clk  - the only clock
//   rst  - synchronous, active-high reset
//   bus  - cr_prefix_fe_seq_if.slave (input words, char bus, result)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready=1, waiting for the next word of the packet
// SHIFT | broadcasting the buffered word one byte per cycle
// DRAIN | collecting the match of the last broadcast character
// OUT   | result presented, waiting for res_ready
module cr_prefix_fe_seq #(
  parameter int NUM_FE    = 16,
  parameter int MAX_CHARS = 256,
  parameter int CNT_W     = 9
) (
  input logic                clk,
  input logic                rst,
  cr_prefix_fe_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, OUT} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHARS);

  state_t            state_q, state_d;
  logic [63:0]       buf_q, buf_d;
  logic [3:0]        bytes_q, bytes_d;
  logic              eop_q, eop_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        char_q, char_d;
  logic              cv_q, cv_d;
  logic              vd_q;
  logic [NUM_FE-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              trunc_q, trunc_d;

  logic [3:0]        in_bytes_eff;
  logic              last_byte;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bytes_d = bytes_q;
    eop_d   = eop_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    char_d  = 8'd0;
    cv_d    = 1'b0;

    in_bytes_eff = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
    last_byte    = ({1'b0, idx_q} == (bytes_q - 4'd1));

    // Comparator outputs lag the char bus by one cycle.
    if (vd_q) begin
      acc_d = acc_q | bus.fe_match_in;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d   = bus.in_data;
          bytes_d = in_bytes_eff;
          eop_d   = bus.in_eop;
          idx_d   = 3'd0;
          if (in_bytes_eff != 4'd0) begin
            state_d = SHIFT;
          end else if (bus.in_eop) begin
            state_d = DRAIN;
          end
        end
      end
      SHIFT: begin
        if (last_byte) begin
          state_d = eop_q ? DRAIN : IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (bus.res_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The char for the cycle we are about to enter is decided now, so the
    // byte is on the bus during the SHIFT cycle it belongs to.
    if (state_d == SHIFT) begin
      char_d = buf_d[{idx_d, 3'b000} +: 8];
      if (cnt_q < MAX_CNT) begin
        cv_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        trunc_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      bytes_q <= '0;
      eop_q   <= 1'b0;
      idx_q   <= '0;
      char_q  <= '0;
      cv_q    <= 1'b0;
      vd_q    <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bytes_q <= bytes_d;
      eop_q   <= eop_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      vd_q    <= cv_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE) && !rst;
  assign bus.fe_char_out   = char_q;
  assign bus.fe_char_valid = cv_q;
  assign bus.res_valid     = (state_q == OUT);
  assign bus.res_vec       = acc_q;
  assign bus.res_char_cnt  = cnt_q;
  assign bus.res_trunc     = trunc_q;

endmodule

// File: tb/tb_cr_prefix_fe_seq.sv
module tb_cr_prefix_fe_seq;
  localparam int NUM_FE    = 16;
  localparam int MAX_CHARS = 256;
  localparam int CNT_W     = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cr_prefix_fe_seq_if #(.NUM_FE(NUM_FE), .CNT_W(CNT_W)) bus ();

  cr_prefix_fe_seq #(.NUM_FE(NUM_FE), .MAX_CHARS(MAX_CHARS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator bank model: registered per-character match, garbage otherwise.
  logic [7:0] tab [NUM_FE];
  logic [NUM_FE-1:0] m_nxt;

  function automatic logic [NUM_FE-1:0] ref_match(input logic [7:0] c);
    logic [NUM_FE-1:0] r;
    for (int i = 0; i < NUM_FE; i++) r[i] = (c == tab[i]);
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.fe_char_valid === 1'b1) m_nxt = ref_match(bus.fe_char_out);
    else m_nxt = NUM_FE'($urandom);
    bus.fe_match_in <= m_nxt;
  end

  logic [7:0] obs_q[$];
  int         obs_cyc[$];
  always @(negedge clk) begin
    if (bus.fe_char_valid === 1'b1) begin
      obs_q.push_back(bus.fe_char_out);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'h40 + 8'($urandom_range(0, 15));
    return w;
  endfunction

  task automatic rand_tab();
    for (int i = 0; i < NUM_FE; i++) tab[i] = 8'h40 + 8'($urandom_range(0, 15));
  endtask

  logic [63:0]       w_data[$];
  logic [3:0]        w_bytes[$];
  logic [NUM_FE-1:0] last_vec;
  logic [CNT_W-1:0]  last_cnt;
  logic              last_trunc;

  task automatic send_pkt(input string tag, input int stall);
    logic [7:0]        eb[$];
    logic [63:0]       tmp;
    logic [NUM_FE-1:0] ev;
    int                k, ecnt, acc_c, bud, k_first;
    bit                etr, same;
    // Reference: flat byte list, first MAX_CHARS compared, rest discarded.
    k_first = 0;
    foreach (w_data[w]) begin
      tmp = w_data[w];
      k = (w_bytes[w] > 4'd8) ? 8 : int'(w_bytes[w]);
      if (w == 0) k_first = k;
      for (int i = 0; i < k; i++) eb.push_back(tmp[8*i +: 8]);
    end
    ecnt = (eb.size() > MAX_CHARS) ? MAX_CHARS : eb.size();
    etr  = (eb.size() > MAX_CHARS);
    ev   = '0;
    for (int i = 0; i < ecnt; i++) ev |= ref_match(eb[i]);

    obs_q.delete();
    obs_cyc.delete();
    acc_c = 0;
    foreach (w_data[w]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w_data[w];
      bus.in_bytes = w_bytes[w];
      bus.in_eop   = (w == w_data.size() - 1);
      bud = 0;
      while (bus.in_ready !== 1'b1 && bud < 1000) begin
        @(negedge clk);
        bud++;
      end
      if (bud >= 1000) begin
        errors++;
        $display("FAIL %s_in_timeout: in_ready stuck low, required 1", tag);
      end
      acc_c = cyc;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;

    bud = 0;
    while (bus.res_valid !== 1'b1 && bud < 4000) begin
      @(negedge clk);
      bud++;
    end
    if (bud >= 4000) begin
      errors++;
      $display("FAIL %s_res_timeout: res_valid never rose, required 1", tag);
    end

    if (w_data.size() == 1) begin
      chk({tag, "_latency"}, 64'(cyc - acc_c), 64'(k_first + 2));
      same = (obs_cyc.size() == k_first);
      for (int i = 0; i < obs_cyc.size(); i++)
        if (obs_cyc[i] != acc_c + 1 + i) same = 0;
      chk({tag, "_char_timing"}, 64'(same), 64'(1));
    end
    chk({tag, "_vec"},    64'(bus.res_vec),      64'(ev));
    chk({tag, "_cnt"},    64'(bus.res_char_cnt), 64'(ecnt));
    chk({tag, "_trunc"},  64'(bus.res_trunc),    64'(etr));
    chk({tag, "_pulses"}, 64'(obs_q.size()),     64'(ecnt));
    same = (obs_q.size() == ecnt);
    for (int i = 0; i < obs_q.size() && i < ecnt; i++)
      if (obs_q[i] !== eb[i]) same = 0;
    chk({tag, "_stream"}, 64'(same), 64'(1));
    last_vec   = bus.res_vec;
    last_cnt   = bus.res_char_cnt;
    last_trunc = bus.res_trunc;

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(bus.res_valid),     64'(1));
      chk({tag, "_stall_vec"},   64'(bus.res_vec),       64'(ev));
      chk({tag, "_stall_rdy"},   64'(bus.in_ready),      64'(0));
      chk({tag, "_stall_char"},  64'(bus.fe_char_valid), 64'(0));
    end

    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk({tag, "_post_rdy"},   64'(bus.in_ready),     64'(1));
    chk({tag, "_post_valid"}, 64'(bus.res_valid),    64'(0));
    chk({tag, "_post_vec"},   64'(bus.res_vec),      64'(0));
    chk({tag, "_post_cnt"},   64'(bus.res_char_cnt), 64'(0));
  endtask

  initial begin
    logic [63:0] rw;
    int          acc_c, bud;
    bit          saw;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bytes  = '0;
    bus.in_eop    = 1'b0;
    bus.res_ready = 1'b0;
    rand_tab();

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),      64'(1));
    chk("rst_char_v",    64'(bus.fe_char_valid), 64'(0));
    chk("rst_char",      64'(bus.fe_char_out),   64'(0));
    chk("rst_res_valid", 64'(bus.res_valid),     64'(0));
    chk("rst_res_vec",   64'(bus.res_vec),       64'(0));
    chk("rst_res_cnt",   64'(bus.res_char_cnt),  64'(0));
    chk("rst_res_trunc", 64'(bus.res_trunc),     64'(0));
    repeat (3) @(negedge clk);
    chk("idle_char_v",   64'(bus.fe_char_valid), 64'(0));

    // "ABC" with 'B' on comparator 2
    for (int i = 0; i < NUM_FE; i++) tab[i] = 8'h60 + 8'(i);
    tab[2] = 8'h42;
    w_data  = '{64'h0000_0000_0043_4241};
    w_bytes = '{4'd3};
    send_pkt("abc", 0);
    chk("abc_vec_const", 64'(last_vec), 64'h0004);
    chk("abc_cnt_const", 64'(last_cnt), 64'd3);

    // Over and exactly at the character limit
    rand_tab();
    w_data.delete(); w_bytes.delete();
    for (int i = 0; i < 40; i++) begin w_data.push_back(rand_word()); w_bytes.push_back(4'd8); end
    send_pkt("trunc40", 0);
    chk("trunc40_trunc_const", 64'(last_trunc), 64'(1));
    w_data.delete(); w_bytes.delete();
    for (int i = 0; i < 32; i++) begin w_data.push_back(rand_word()); w_bytes.push_back(4'd8); end
    send_pkt("exact32", 0);
    chk("exact32_cnt_const", 64'(last_cnt), 64'd256);

    // Result back-pressure, then a fresh packet must not carry stale bits
    rand_tab();
    w_data  = '{rand_word(), rand_word()};
    w_bytes = '{4'd8, 4'd5};
    send_pkt("stall", 10);
    w_data  = '{rand_word()};
    w_bytes = '{4'd2};
    send_pkt("after_stall", 0);

    // Empty packet
    w_data  = '{rand_word()};
    w_bytes = '{4'd0};
    send_pkt("empty", 0);

    // Oversized byte count is treated as 8
    w_data  = '{rand_word()};
    w_bytes = '{4'd13};
    send_pkt("bytes13", 1);

    // Reset during byte 4 of an 8-byte word
    rw = rand_word();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = rw;
    bus.in_bytes = 4'd8;
    bus.in_eop   = 1'b1;
    bud = 0;
    while (bus.in_ready !== 1'b1 && bud < 100) begin @(negedge clk); bud++; end
    acc_c = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_char_v",  64'(bus.fe_char_valid), 64'(1));
    chk("rstmid_char",    64'(bus.fe_char_out),   64'(rw[31:24]));
    chk("rstmid_cycle",   64'(cyc - acc_c),       64'(4));
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_char_v_off", 64'(bus.fe_char_valid), 64'(0));
    rst = 1'b0;
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.fe_char_valid !== 1'b0) saw = 1;
    end
    chk("rstmid_no_result", 64'(saw), 64'(0));
    w_data  = '{rand_word()};
    w_bytes = '{4'd6};
    send_pkt("post_rst", 0);

    // Randomized packets
    for (int p = 0; p < 25; p++) begin
      rand_tab();
      w_data.delete(); w_bytes.delete();
      for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
        w_data.push_back(rand_word());
        w_bytes.push_back(4'($urandom_range(0, 15)));
      end
      send_pkt($sformatf("rnd%0d", p), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr_prefix_fe_seq.md
Name: cr_prefix_fe_seq

Overview:
Sequencer for the prefix feature-extraction character comparator bank. Accepts packet data as 64-bit words, serializes them into one byte per cycle onto the shared char bus that feeds all NUM_FE comparators, and collects their registered match outputs. It accumulates a per-packet sticky feature vector and presents it with a character count on a valid/ready result interface. It sits between the prefix input FIFO and the prefix table lookup stage.

Parameters:
NUM_FE, 16, number of feature comparators on the char bus (match vector width).
MAX_CHARS, 256, maximum characters per packet that are compared; later bytes are discarded.
CNT_W, 9, width of the character counter; must satisfy 2^CNT_W > MAX_CHARS.

Ports:
clk  input  1  clock, the only clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input word valid.
in_ready  output  1  input word accepted when in_valid & in_ready.
in_data  input  64  packet bytes; byte 0 = bits [7:0] is sent first.
in_bytes  input  4  valid bytes in the word, 0..8; values 9..15 are treated as 8.
in_eop  input  1  last word of the packet.
fe_char_out  output  8  character broadcast to the comparators.
fe_char_valid  output  1  fe_char_out is valid this cycle.
fe_match_in  input  NUM_FE  comparator match outputs, valid the cycle after fe_char_valid.
res_valid  output  1  result valid.
res_ready  input  1  result consumed when res_valid & res_ready.
res_vec  output  NUM_FE  OR of fe_match_in over all compared characters of the packet.
res_char_cnt  output  CNT_W  number of characters compared (at most MAX_CHARS).
res_trunc  output  1  packet had more than MAX_CHARS bytes.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=0 while rst is high, then 1 in IDLE. fe_char_valid=0, fe_char_out=0, res_valid=0, res_vec=0, res_char_cnt=0, res_trunc=0. The word buffer, byte index, and valid-delay flag all clear.
- Reset mid-operation drops the packet in progress. No result is produced for it.
- States are IDLE, SHIFT, DRAIN and OUT.
- IDLE:
  - in_ready=1.
  - On accept, latch in_data, in_bytes and in_eop, and set byte index=0.
  - If in_bytes!=0, go to SHIFT.
  - If in_bytes==0 and in_eop=1, go to DRAIN.
  - If in_bytes==0 and in_eop=0, stay in IDLE (the word is consumed with no chars).
- SHIFT:
  - in_ready=0. Each cycle, byte[index] is placed on fe_char_out, registered so it is visible the cycle after the decision.
  - fe_char_valid=1 only if the count is below MAX_CHARS. In that case count increments. Otherwise set trunc=1 and fe_char_valid=0 (the byte is discarded).
  - After index==in_bytes-1: if eop, go to DRAIN; otherwise go to IDLE.
  - A word of k bytes therefore takes k SHIFT cycles plus 1 IDLE accept cycle.
- Match capture:
  - Register vd = fe_char_valid. When vd==1, acc |= fe_match_in.
  - fe_match_in is ignored when vd==0.
- DRAIN: one cycle that captures the match for the final character. Then go to OUT.
- OUT:
  - res_valid=1; res_vec=acc; res_char_cnt=count; res_trunc=trunc. All are held stable until res_ready.
  - On handshake, clear acc, count and trunc, and go to IDLE.
  - If res_ready is already high on the first OUT cycle, the result is consumed that cycle.
- Latency: from accepting an eop word with k bytes to res_valid is k+2 cycles (k SHIFT, 1 DRAIN, with OUT registered).
- Empty packet (a single eop word with in_bytes=0): result res_vec=0, cnt=0, trunc=0.
- Truncation boundary: a count of exactly MAX_CHARS gives trunc=0. Only a byte arriving while count==MAX_CHARS sets trunc.
- The counter saturates at MAX_CHARS and never wraps.
- No back-to-back overlap: the next packet's first word is not accepted until the result handshake completes.

Test Plan:
- Reset held 3 cycles, then released, with in_valid=0 -> in_ready=1, all outputs 0, fe_char_valid stays 0.
- One eop word, in_data=0x0000_0000_0043_4241, in_bytes=3; comparator model matches 'B' on bit 2 -> fe_char_out sequence 0x41, 0x42, 0x43 on 3 consecutive cycles; res_vec=0x0004, res_char_cnt=3, res_trunc=0; res_valid 5 cycles after accept.
- 40 full words (320 bytes) with MAX_CHARS=256 -> exactly 256 fe_char_valid pulses, res_char_cnt=256, res_trunc=1. Repeat with 32 words -> cnt=256, trunc=0.
- res_ready held low 10 cycles in OUT -> res_valid/res_vec stable, in_ready=0, no fe_char_valid; res_ready high -> next cycle in_ready=1 and accumulator cleared (next packet's result does not include stale bits).
- Empty packet (in_bytes=0, in_eop=1) -> no fe_char_valid, res_valid after 2 cycles with vec=0, cnt=0.
- rst asserted during SHIFT of byte 4 of an 8-byte word -> next cycle fe_char_valid=0, res_valid never asserts for that packet; following packet produces a correct independent result.
